// File: rtl/store_unit_pkg.sv
// rtl/store_unit_pkg.sv - shared types, sizes and decode helpers for the vector store unit
//
// Purpose: store_op / lmul / vsew encodings, memory geometry and the small
// decode functions used by both the sequencer and the address generator.
// Ports: none (package).
package store_unit_pkg;

  localparam int VLEN          = 128;
  localparam int NPORTS        = 4;
  localparam int DATAMEM_BITS  = 14;
  localparam int DATAMEM_WIDTH = 32;
  localparam int GROUP_BITS    = VLEN * 4;

  typedef enum logic [3:0] {
    OP_VSE8   = 4'd7,
    OP_VSE16  = 4'd8,
    OP_VSE32  = 4'd9,
    OP_VSSE8  = 4'd10,
    OP_VSSE16 = 4'd11,
    OP_VSSE32 = 4'd12
  } store_op_e;

  typedef enum logic [2:0] {
    LMUL_1 = 3'd0,
    LMUL_2 = 3'd1,
    LMUL_4 = 3'd2
  } lmul_e;

  typedef enum logic [2:0] {
    SEW_8  = 3'd0,
    SEW_16 = 3'd1,
    SEW_32 = 3'd2
  } vsew_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STORE,
    S_DONE
  } state_e;

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_VSE8) && (op <= OP_VSSE32);
  endfunction

  function automatic logic is_strided(input logic [3:0] op);
    return (op >= OP_VSSE8) && (op <= OP_VSSE32);
  endfunction

  // Element width in bytes; non-store codes fall through to 4 but are never issued.
  function automatic logic [2:0] eew_bytes(input logic [3:0] op);
    case (op)
      OP_VSE8,  OP_VSSE8:  return 3'd1;
      OP_VSE16, OP_VSSE16: return 3'd2;
      default:             return 3'd4;
    endcase
  endfunction

  // Beats = (VLEN/EEW)*LMUL/NPORTS, always a power of two in 1..16.
  function automatic logic [4:0] num_beats(input logic [3:0] op, input logic [2:0] lmul);
    logic [2:0] lmul_sh;
    logic [2:0] eew_sh;
    case (lmul)
      LMUL_1:  lmul_sh = 3'd0;
      LMUL_2:  lmul_sh = 3'd1;
      default: lmul_sh = 3'd2;
    endcase
    case (eew_bytes(op))
      3'd1:    eew_sh = 3'd2;
      3'd2:    eew_sh = 3'd1;
      default: eew_sh = 3'd0;
    endcase
    return 5'd1 << (lmul_sh + eew_sh);
  endfunction

endpackage

// File: rtl/store_unit_if.sv
// rtl/store_unit_if.sv - request and memory-write bundle of the vector store unit
//
// Purpose: groups the store request (op, lmul, vsew, stride, base, register
// group) and the four per-bank write lanes plus done.
// Modports: master drives the request and observes writes; slave is the unit.
interface store_unit_if;
  import store_unit_pkg::*;

  logic [3:0]                                store_op;
  logic [2:0]                                lmul;
  logic [2:0]                                vsew;
  logic [4:0]                                stride;
  logic [DATAMEM_BITS-1:0]                   address;
  logic [GROUP_BITS-1:0]                     data;
  logic [NPORTS-1:0][DATAMEM_BITS-1:0]       data_addr;
  logic [NPORTS-1:0][DATAMEM_WIDTH-1:0]      data_out;
  logic                                      done;

  modport master (
    output store_op, lmul, vsew, stride, address, data,
    input  data_addr, data_out, done
  );

  modport slave (
    input  store_op, lmul, vsew, stride, address, data,
    output data_addr, data_out, done
  );

endinterface

// File: rtl/store_addr_gen.sv
// rtl/store_addr_gen.sv - per-beat address and element slice generator
//
// Purpose: for beat index k, computes the byte address and zero-extended
// element for each port p, element i = 4k+p. Purely combinational.
// Ports: op_i, stride_i, base_i, beat_i, data_i in; addr_o, elem_o out.
module store_addr_gen
  import store_unit_pkg::*;
(
  input  logic [3:0]                           op_i,
  input  logic [4:0]                           stride_i,
  input  logic [DATAMEM_BITS-1:0]              base_i,
  input  logic [3:0]                           beat_i,
  input  logic [GROUP_BITS-1:0]                data_i,
  output logic [NPORTS-1:0][DATAMEM_BITS-1:0]  addr_o,
  output logic [NPORTS-1:0][DATAMEM_WIDTH-1:0] elem_o
);

  logic [2:0]              eb;
  logic [4:0]              step;
  logic [DATAMEM_BITS-1:0] byte_step;
  logic [5:0]              idx;
  logic [10:0]             bitpos;
  logic [31:0]             raw;

  always_comb begin
    eb        = eew_bytes(op_i);
    // Unit-stride is just stride 1 in element units.
    step      = is_strided(op_i) ? stride_i : 5'd1;
    byte_step = DATAMEM_BITS'(step) * DATAMEM_BITS'(eb);
    idx       = '0;
    bitpos    = '0;
    raw       = '0;
    addr_o    = '0;
    elem_o    = '0;
    for (int p = 0; p < NPORTS; p++) begin
      idx       = {beat_i, 2'(p)};
      // Truncation to DATAMEM_BITS gives the modulo-2^N address wrap.
      addr_o[p] = base_i + DATAMEM_BITS'(idx) * byte_step;
      bitpos    = 11'(idx) * 11'({eb, 3'b000});
      raw       = 32'(data_i >> bitpos);
      case (eb)
        3'd1:    elem_o[p] = {24'd0, raw[7:0]};
        3'd2:    elem_o[p] = {16'd0, raw[15:0]};
        default: elem_o[p] = raw;
      endcase
    end
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - vector store address/data sequencer
//
// Purpose: latches a vector store op and issues its elements four per beat,
// one per memory bank, then holds done until store_op drops.
// Ports: clk, rst (sync, active-high); bus (store_unit_if.slave) carrying
// store_op/lmul/vsew/stride/address/data in and data_addr/data_out/done out.
module store_unit
  import store_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  store_unit_if.slave  bus
);

  state_e                               state_q;
  logic [3:0]                           op_q;
  logic [4:0]                           stride_q;
  logic [DATAMEM_BITS-1:0]              base_q;
  logic [GROUP_BITS-1:0]                data_q;
  logic [4:0]                           beat_q;
  logic [4:0]                           nbeats_q;
  logic [NPORTS-1:0][DATAMEM_BITS-1:0]  addr_q;
  logic [NPORTS-1:0][DATAMEM_WIDTH-1:0] dout_q;
  logic                                 done_q;

  logic                                 idle;
  logic [3:0]                           gen_op;
  logic [4:0]                           gen_stride;
  logic [DATAMEM_BITS-1:0]              gen_base;
  logic [GROUP_BITS-1:0]                gen_data;
  logic [3:0]                           gen_beat;
  logic [NPORTS-1:0][DATAMEM_BITS-1:0]  gen_addr;
  logic [NPORTS-1:0][DATAMEM_WIDTH-1:0] gen_elem;

  // vsew is architecturally ignored: EEW is carried by store_op.
  logic unused_vsew;
  assign unused_vsew = ^bus.vsew;

  // Beat 0 is registered on the start edge, before the request is latched,
  // so in IDLE the generator looks at the live inputs.
  assign idle       = (state_q == S_IDLE);
  assign gen_op     = idle ? bus.store_op : op_q;
  assign gen_stride = idle ? bus.stride   : stride_q;
  assign gen_base   = idle ? bus.address  : base_q;
  assign gen_data   = idle ? bus.data     : data_q;
  assign gen_beat   = idle ? 4'd0         : beat_q[3:0];

  store_addr_gen u_addr_gen (
    .op_i     (gen_op),
    .stride_i (gen_stride),
    .base_i   (gen_base),
    .beat_i   (gen_beat),
    .data_i   (gen_data),
    .addr_o   (gen_addr),
    .elem_o   (gen_elem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      stride_q <= '0;
      base_q   <= '0;
      data_q   <= '0;
      beat_q   <= '0;
      nbeats_q <= '0;
      addr_q   <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_store(bus.store_op)) begin
            op_q     <= bus.store_op;
            stride_q <= bus.stride;
            base_q   <= bus.address;
            data_q   <= bus.data;
            nbeats_q <= num_beats(bus.store_op, bus.lmul);
            beat_q   <= 5'd1;
            addr_q   <= gen_addr;
            dout_q   <= gen_elem;
            state_q  <= S_STORE;
          end
        end
        S_STORE: begin
          // beat_q is the index of the next beat to issue.
          if (beat_q == nbeats_q) begin
            addr_q  <= '0;
            dout_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            addr_q <= gen_addr;
            dout_q <= gen_elem;
            beat_q <= beat_q + 5'd1;
          end
        end
        S_DONE: begin
          if (!is_store(bus.store_op)) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          addr_q  <= '0;
          dout_q  <= '0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.data_addr = addr_q;
  assign bus.data_out  = dout_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - self-checking bench for store_unit
module tb_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_unit_if bus_if ();

  store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  typedef struct packed {
    logic [3:0][13:0] a;
    logic [3:0][31:0] d;
    logic             done;
  } snap_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  bit    chk_on   = 1'b0;
  snap_t cur      = '0;
  snap_t exp_q[$];
  bit    in_done  = 1'b0;

  function automatic bit is_st(input logic [3:0] op);
    return (op >= 4'd7) && (op <= 4'd12);
  endfunction

  // Schedule every cycle of a store from its element list: beat k holds
  // elements 4k..4k+3, followed by a single done cycle.
  function automatic void build(input logic [3:0] op, input logic [2:0] lm,
                                input logic [4:0] st, input logic [13:0] ad,
                                input logic [511:0] dt);
    int    eb, ebits, step, lmv, n;
    snap_t s;
    eb    = 1 << ((int'(op) - 7) % 3);
    ebits = eb * 8;
    step  = (op >= 4'd10) ? int'(st) : 1;
    lmv   = (lm == 3'd0) ? 1 : (lm == 3'd1) ? 2 : 4;
    n     = (128 / ebits) * lmv;
    s     = '0;
    for (int i = 0; i < n; i++) begin
      if (i % 4 == 0) s = '0;
      s.a[i % 4] = 14'((int'(ad) + i * step * eb) % 16384);
      s.d[i % 4] = 32'((dt >> (i * ebits)) & ((512'd1 << ebits) - 512'd1));
      if (i % 4 == 3) exp_q.push_back(s);
    end
    s      = '0;
    s.done = 1'b1;
    exp_q.push_back(s);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_done = 1'b0;
      cur     = '0;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (exp_q.size() == 0) in_done = 1'b1;
    end else if (in_done) begin
      if (!is_st(bus_if.store_op)) begin
        in_done = 1'b0;
        cur     = '0;
      end
    end else if (is_st(bus_if.store_op)) begin
      build(bus_if.store_op, bus_if.lmul, bus_if.stride, bus_if.address, bus_if.data);
      cur = exp_q.pop_front();
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_checks++;
      if ({bus_if.data_addr, bus_if.data_out, bus_if.done} !== cur) begin
        n_fail++;
        $display("FAIL model t=%0t: addr=%h data=%h done=%b expected addr=%h data=%h done=%b",
                 $time, bus_if.data_addr, bus_if.data_out, bus_if.done, cur.a, cur.d, cur.done);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] op, input logic [2:0] lm, input logic [4:0] st,
                         input logic [13:0] ad, input logic [511:0] dt);
    bus_if.store_op = op;
    bus_if.lmul     = lm;
    bus_if.vsew     = 3'($urandom_range(0, 7));
    bus_if.stride   = st;
    bus_if.address  = ad;
    bus_if.data     = dt;
  endtask

  function automatic logic [511:0] rand_group();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  logic [511:0] dv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_req(4'd0, 3'd0, 5'd0, 14'd0, '0);
    rst = 1'b1;
    tick(3);
    chk_on = 1'b1;
    chk("reset addr", 128'(bus_if.data_addr), 128'd0);
    chk("reset data", bus_if.data_out, 128'd0);
    chk("reset done", 128'(bus_if.done), 128'd0);
    rst = 1'b0;
    tick();

    // strided e32, single beat
    dv = '0;
    dv[127:0] = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    set_req(4'd12, 3'd0, 5'd2, 14'h0, dv);
    tick();
    chk("t1 addr", 128'(bus_if.data_addr), 128'({14'h18, 14'h10, 14'h08, 14'h00}));
    chk("t1 data", bus_if.data_out, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000});
    bus_if.store_op = 4'd0;
    tick();
    chk("t1 cleared", bus_if.data_out, 128'd0);
    chk("t1 done", 128'(bus_if.done), 128'd1);
    tick();
    chk("t1 rearm", 128'(bus_if.done), 128'd0);

    // unit-stride e32, LMUL=2
    dv = '0;
    for (int w = 0; w < 8; w++) dv[w*32 +: 32] = 32'h11111111 * w;
    set_req(4'd9, 3'd1, 5'd0, 14'h100, dv);
    tick();
    chk("t2 b0 addr", 128'(bus_if.data_addr), 128'({14'h10C, 14'h108, 14'h104, 14'h100}));
    chk("t2 b0 data", bus_if.data_out, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000});
    bus_if.store_op = 4'd0;
    tick();
    chk("t2 b1 addr", 128'(bus_if.data_addr), 128'({14'h11C, 14'h118, 14'h114, 14'h110}));
    chk("t2 b1 data", bus_if.data_out, {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444});
    tick();
    chk("t2 done", 128'(bus_if.done), 128'd1);
    tick();

    // unit-stride e8
    dv = '0;
    for (int b = 0; b < 16; b++) dv[b*8 +: 8] = 8'(b);
    set_req(4'd7, 3'd0, 5'd0, 14'h0, dv);
    tick();
    chk("t3 b0 addr", 128'(bus_if.data_addr), 128'({14'h3, 14'h2, 14'h1, 14'h0}));
    chk("t3 b0 data", bus_if.data_out, {32'h3, 32'h2, 32'h1, 32'h0});
    bus_if.store_op = 4'd0;
    tick(3);
    chk("t3 b3 no done", 128'(bus_if.done), 128'd0);
    chk("t3 b3 data", bus_if.data_out, {32'hF, 32'hE, 32'hD, 32'hC});
    tick();
    chk("t3 done", 128'(bus_if.done), 128'd1);
    tick();

    // strided e16, zero stride
    dv = '0;
    for (int h = 0; h < 8; h++) dv[h*16 +: 16] = 16'h1000 + 16'(h);
    set_req(4'd11, 3'd0, 5'd0, 14'h40, dv);
    tick();
    chk("t4 b0 addr", 128'(bus_if.data_addr), 128'({4{14'h40}}));
    chk("t4 b0 data", bus_if.data_out, {32'h1003, 32'h1002, 32'h1001, 32'h1000});
    bus_if.store_op = 4'd0;
    tick();
    chk("t4 b1 addr", 128'(bus_if.data_addr), 128'({4{14'h40}}));
    chk("t4 b1 data", bus_if.data_out, {32'h1007, 32'h1006, 32'h1005, 32'h1004});
    tick();
    chk("t4 done", 128'(bus_if.done), 128'd1);
    tick();

    // reset mid-burst, then restart
    dv = '0;
    for (int w = 0; w < 16; w++) dv[w*32 +: 32] = 32'hA0000000 + 32'(w);
    set_req(4'd9, 3'd2, 5'd0, 14'h200, dv);
    tick(2);
    chk("t5 b1 addr", 128'(bus_if.data_addr), 128'({14'h21C, 14'h218, 14'h214, 14'h210}));
    rst = 1'b1;
    tick();
    chk("t5 rst addr", 128'(bus_if.data_addr), 128'd0);
    chk("t5 rst data", bus_if.data_out, 128'd0);
    chk("t5 rst done", 128'(bus_if.done), 128'd0);
    rst = 1'b0;
    tick();
    chk("t5 restart addr", 128'(bus_if.data_addr), 128'({14'h20C, 14'h208, 14'h204, 14'h200}));
    chk("t5 restart data", bus_if.data_out, {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000});

    // rearm: store_op held at a store keeps done and issues nothing
    bus_if.store_op = 4'd12;
    tick(4);
    chk("t6 done", 128'(bus_if.done), 128'd1);
    tick(2);
    chk("t6 held done", 128'(bus_if.done), 128'd1);
    chk("t6 no beats", 128'(bus_if.data_addr), 128'd0);
    bus_if.store_op = 4'd0;
    tick();
    chk("t6 released", 128'(bus_if.done), 128'd0);
    bus_if.store_op = 4'd9;
    tick();
    chk("t6 new burst", 128'(bus_if.data_addr), 128'({14'h20C, 14'h208, 14'h204, 14'h200}));
    bus_if.store_op = 4'd0;
    tick(6);

    // randomized traffic with input scrambling and occasional resets
    for (int t = 0; t < 40; t++) begin
      set_req(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(7, 12)),
              3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
              14'($urandom_range(0, 16383)), rand_group());
      for (int c = 0; c < 20; c++) begin
        tick();
        rst = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 1) == 1)
          set_req(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  14'($urandom_range(0, 16383)), rand_group());
      end
      rst = 1'b0;
      bus_if.store_op = 4'd0;
      tick(2);
    end

    bus_if.store_op = 4'd0;
    tick(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
